averager_sequencer: RTL and testbench

Control sequencer for the averager counter: latches a software configuration, arms the averager through its `restart`/`ready` handshake, and runs a programmed number of averaging acquisitions or runs continuously. Sits between the AXI config/status registers and the averager counter. Stable `count_max`/`avg_on` are presented to the averager, and it reports per-acquisition completion, the measured `n_avg`, and watchdog errors.

---
 rtl/averager_seq_pkg.sv | 17 +
 rtl/seq_watchdog.sv | 37 +++
 rtl/averager_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_averager_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/averager_seq_pkg.sv
// Shared types and default widths for the averager control sequencer.
package averager_seq_pkg;

    localparam int FAST_COUNT_WIDTH_DEF = 13;
    localparam int SLOW_COUNT_WIDTH_DEF = 19;
    localparam int NACQ_WIDTH_DEF       = 16;
    localparam int TIMEOUT_WIDTH_DEF    = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_RESTART  = 3'd2,
        ST_ACQUIRE  = 3'd3,
        ST_COMPLETE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts while enabled, restarts on clear, flags when the
// count reaches a nonzero limit. A zero limit never expires.
module seq_watchdog #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             w_limit_on;

    assign w_limit_on = (i_limit != '0);

    // Elapsed-cycle counter for the current watched state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    // Fires in the limit-th watched cycle so the caller leaves on that edge.
    assign o_expired = i_enable && w_limit_on && (r_count == (i_limit - ONE));

endmodule

// File: rtl/averager_sequencer.sv
// Control sequencer for the averager counter: latches configuration, drives
// the restart/ready handshake and runs finite or continuous acquisitions.
module averager_sequencer
    import averager_seq_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_DEF,
    parameter int SLOW_COUNT_WIDTH = SLOW_COUNT_WIDTH_DEF,
    parameter int NACQ_WIDTH       = NACQ_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH    = TIMEOUT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [FAST_COUNT_WIDTH-1:0] cfg_count_max,
    input  logic                        cfg_avg_on,
    input  logic [NACQ_WIDTH-1:0]       cfg_n_acq,
    input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
    input  logic                        avg_ready,
    input  logic [SLOW_COUNT_WIDTH-1:0] avg_n_avg,
    output logic                        avg_restart,
    output logic [FAST_COUNT_WIDTH-1:0] avg_count_max,
    output logic                        avg_avg_on,
    output logic                        busy,
    output logic                        done,
    output logic                        run_done,
    output logic [NACQ_WIDTH-1:0]       acq_count,
    output logic [SLOW_COUNT_WIDTH-1:0] last_n_avg,
    output logic                        error
);

    localparam logic [NACQ_WIDTH-1:0] ACQ_ONE = NACQ_WIDTH'(1);

    seq_state_t                  r_state;
    seq_state_t                  w_next;
    logic [NACQ_WIDTH-1:0]       r_n_acq;
    logic [TIMEOUT_WIDTH-1:0]    r_timeout;
    logic [FAST_COUNT_WIDTH-1:0] r_count_max;
    logic                        r_avg_on;
    logic [NACQ_WIDTH-1:0]       r_acq_count;
    logic [SLOW_COUNT_WIDTH-1:0] r_last_n_avg;
    logic                        r_avg_restart;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_run_done;
    logic                        r_error;

    logic [NACQ_WIDTH-1:0]       w_acq_inc;
    logic                        w_run_end;
    logic                        w_start_run;
    logic                        w_complete;
    logic                        w_timeout_hit;
    logic                        w_wd_clear;
    logic                        w_wd_enable;
    logic                        w_wd_expired;

    assign w_acq_inc   = r_acq_count + ACQ_ONE;
    assign w_run_end   = (r_n_acq != '0) && (w_acq_inc == r_n_acq);
    assign w_wd_enable = (r_state == ST_RESTART) || (r_state == ST_ACQUIRE);

    seq_watchdog #(
        .WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .i_limit  (r_timeout),
        .o_expired(w_wd_expired)
    );

    // Next-state decode; abort outranks every other event in a busy state.
    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        w_complete    = 1'b0;
        w_start_run   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next      = ST_ARM;
                    w_start_run = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (avg_ready) begin
                    w_next = ST_RESTART;
                end else begin
                    w_next = ST_ARM;
                end
            end
            ST_RESTART: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_wd_expired) begin
                    w_next        = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else if (!avg_ready) begin
                    w_next = ST_ACQUIRE;
                end else begin
                    w_next = ST_RESTART;
                end
            end
            ST_ACQUIRE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_wd_expired) begin
                    w_next        = ST_IDLE;
                    w_timeout_hit = 1'b1;
                end else if (avg_ready) begin
                    w_next = ST_COMPLETE;
                end else begin
                    w_next = ST_ACQUIRE;
                end
            end
            ST_COMPLETE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_run_end) begin
                    w_next     = ST_IDLE;
                    w_complete = 1'b1;
                end else begin
                    w_next     = ST_ARM;
                    w_complete = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The watchdog restarts on every entry into a watched state.
    always_comb begin
        w_wd_clear = 1'b0;
        if ((w_next == ST_RESTART) && (r_state != ST_RESTART)) begin
            w_wd_clear = 1'b1;
        end else if ((w_next == ST_ACQUIRE) && (r_state != ST_ACQUIRE)) begin
            w_wd_clear = 1'b1;
        end else begin
            w_wd_clear = 1'b0;
        end
    end

    // State register and the status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_avg_restart <= 1'b0;
            r_done        <= 1'b0;
            r_run_done    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != ST_IDLE);
            r_avg_restart <= (w_next == ST_RESTART);
            r_done        <= w_complete;
            r_run_done    <= w_complete && w_run_end;
        end
    end

    // Run configuration is captured only when a run begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_max <= '1;
            r_avg_on    <= 1'b0;
            r_n_acq     <= '0;
            r_timeout   <= '0;
        end else if (w_start_run) begin
            r_count_max <= cfg_count_max;
            r_avg_on    <= cfg_avg_on;
            r_n_acq     <= cfg_n_acq;
            r_timeout   <= cfg_timeout;
        end else begin
            r_count_max <= r_count_max;
            r_avg_on    <= r_avg_on;
            r_n_acq     <= r_n_acq;
            r_timeout   <= r_timeout;
        end
    end

    // Acquisition bookkeeping and the sticky watchdog flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acq_count  <= '0;
            r_last_n_avg <= '0;
            r_error      <= 1'b0;
        end else if (w_start_run) begin
            r_acq_count  <= '0;
            r_last_n_avg <= r_last_n_avg;
            r_error      <= 1'b0;
        end else begin
            if (w_complete) begin
                r_acq_count  <= w_acq_inc;
                r_last_n_avg <= avg_n_avg;
            end else begin
                r_acq_count  <= r_acq_count;
                r_last_n_avg <= r_last_n_avg;
            end
            if (w_timeout_hit) begin
                r_error <= 1'b1;
            end else begin
                r_error <= r_error;
            end
        end
    end

    assign avg_restart   = r_avg_restart;
    assign avg_count_max = r_count_max;
    assign avg_avg_on    = r_avg_on;
    assign busy          = r_busy;
    assign done          = r_done;
    assign run_done      = r_run_done;
    assign acq_count     = r_acq_count;
    assign last_n_avg    = r_last_n_avg;
    assign error         = r_error;

endmodule

// File: tb/tb_averager_sequencer.sv
// Self-checking bench: a behavioural averager drives the handshake and each
// task checks one feature of the sequencer against expectations built here.
module tb_averager_sequencer;

    localparam int FW = 13;
    localparam int SW = 19;
    localparam int NW = 4;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] cfg_count_max = '0;
    logic          cfg_avg_on = 1'b0;
    logic [NW-1:0] cfg_n_acq = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          avg_ready;
    logic [SW-1:0] avg_n_avg;
    logic          avg_restart;
    logic [FW-1:0] avg_count_max;
    logic          avg_avg_on;
    logic          busy;
    logic          done;
    logic          run_done;
    logic [NW-1:0] acq_count;
    logic [SW-1:0] last_n_avg;
    logic          error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_rise_cyc = 0;
    int m_remaining = 0;
    bit m_clken = 1'b1;

    averager_sequencer #(
        .FAST_COUNT_WIDTH(FW),
        .SLOW_COUNT_WIDTH(SW),
        .NACQ_WIDTH      (NW),
        .TIMEOUT_WIDTH   (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_count_max(cfg_count_max),
        .cfg_avg_on   (cfg_avg_on),
        .cfg_n_acq    (cfg_n_acq),
        .cfg_timeout  (cfg_timeout),
        .avg_ready    (avg_ready),
        .avg_n_avg    (avg_n_avg),
        .avg_restart  (avg_restart),
        .avg_count_max(avg_count_max),
        .avg_avg_on   (avg_avg_on),
        .busy         (busy),
        .done         (done),
        .run_done     (run_done),
        .acq_count    (acq_count),
        .last_n_avg   (last_n_avg),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Averager model: restart (sampled on clken) drops ready for 1-2 periods
    // of count_max+1 cycles, then ready returns with a fresh n_avg.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_ready   <= 1'b1;
            avg_n_avg   <= '0;
            m_remaining <= 0;
        end else if (m_clken) begin
            if (avg_restart) begin
                avg_ready   <= 1'b0;
                m_remaining <= (int'(avg_count_max) + 1) * int'($urandom_range(2, 1));
            end else if (!avg_ready) begin
                if (m_remaining <= 1) begin
                    avg_ready  <= 1'b1;
                    avg_n_avg  <= SW'($urandom);
                    m_rise_cyc <= cyc + 1;
                end else begin
                    m_remaining <= m_remaining - 1;
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (avg_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy, avg_restart, avg_avg_on, done, run_done, error} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {busy, avg_restart, avg_avg_on, done, run_done, error});
        end
        total++; if (avg_count_max !== 13'h1FFF) begin
            bad++; $display("FAIL reset_count_max got=%0h exp=1fff", avg_count_max);
        end
        total++; if (acq_count !== 4'd0 || last_n_avg !== 19'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", acq_count, last_n_avg);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_finite_run();
        logic [NW-1:0] exp_acq;
        logic [NW-1:0] acq_snap;
        int n_done, n_run;
        bit injected, finished, check_snap;
        exp_acq = '0; n_done = 0; n_run = 0;
        injected = 1'b0; finished = 1'b0; check_snap = 1'b0; acq_snap = '0;
        cfg_count_max = 13'd7; cfg_avg_on = 1'b1; cfg_n_acq = 4'd3; cfg_timeout = 24'd1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin
            bad++; $display("FAIL start_busy got=%b exp=1", busy);
        end
        total++; if (avg_count_max !== 13'd7 || avg_avg_on !== 1'b1) begin
            bad++; $display("FAIL latch_cfg got=%0d/%b exp=7/1", avg_count_max, avg_avg_on);
        end
        for (int i = 0; i < 2000 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (check_snap) begin
                check_snap = 1'b0;
                total++; if (acq_count !== acq_snap) begin
                    bad++; $display("FAIL busy_start_count got=%0d exp=%0d", acq_count, acq_snap);
                end
                total++; if (avg_count_max !== 13'd7 || avg_avg_on !== 1'b1) begin
                    bad++; $display("FAIL busy_start_cfg got=%0d/%b exp=7/1", avg_count_max, avg_avg_on);
                end
            end
            if (done) begin
                exp_acq = exp_acq + 4'd1;
                n_done++;
                total++; if (acq_count !== exp_acq) begin
                    bad++; $display("FAIL finite_acq got=%0d exp=%0d", acq_count, exp_acq);
                end
                total++; if (last_n_avg !== avg_n_avg) begin
                    bad++; $display("FAIL finite_n_avg got=%0h exp=%0h", last_n_avg, avg_n_avg);
                end
                total++; if (cyc !== m_rise_cyc + 2) begin
                    bad++; $display("FAIL done_latency got=%0d exp=%0d", cyc - m_rise_cyc, 2);
                end
            end
            if (run_done) begin
                n_run++;
                finished = 1'b1;
                total++; if (busy !== 1'b0) begin
                    bad++; $display("FAIL run_done_busy got=%b exp=0", busy);
                end
            end
            if (!injected && n_done == 1 && busy && !avg_restart && !avg_ready) begin
                injected = 1'b1;
                acq_snap = acq_count;
                cfg_count_max = 13'd31; cfg_avg_on = 1'b0; cfg_n_acq = 4'd5;
                start = 1'b1;
                check_snap = 1'b1;
            end
        end
        total++; if (n_done !== 3 || n_run !== 1) begin
            bad++; $display("FAIL finite_totals got=%0d/%0d exp=3/1", n_done, n_run);
        end
    endtask

    task automatic test_config_next_run();
        bit ok;
        bit got;
        cfg_n_acq = 4'd1; cfg_timeout = 24'd0;
        wait_ready(ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (avg_count_max !== 13'd31 || avg_avg_on !== 1'b0) begin
            bad++; $display("FAIL next_run_cfg got=%0d/%b exp=31/0", avg_count_max, avg_avg_on);
        end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (run_done) got = 1'b1;
        end
        total++; if (!got || acq_count !== 4'd1 || last_n_avg !== avg_n_avg) begin
            bad++; $display("FAIL next_run_end got=%b/%0d exp=1/1", got, acq_count);
        end
    endtask

    task automatic test_continuous_abort();
        logic [NW-1:0] exp_acq;
        int n_done, n_run;
        bit ok, wrapped;
        exp_acq = '0; n_done = 0; n_run = 0; wrapped = 1'b0;
        cfg_count_max = 13'd7; cfg_avg_on = 1'b1; cfg_n_acq = 4'd0; cfg_timeout = 24'd0;
        wait_ready(ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4000 && n_done < 18; i++) begin
            @(negedge clk);
            if (run_done) n_run++;
            if (done) begin
                if (exp_acq == 4'd15) wrapped = 1'b1;
                exp_acq = exp_acq + 4'd1;
                n_done++;
                total++; if (acq_count !== exp_acq || last_n_avg !== avg_n_avg) begin
                    bad++; $display("FAIL cont_acq got=%0d/%0h exp=%0d/%0h", acq_count, last_n_avg, exp_acq, avg_n_avg);
                end
            end
        end
        total++; if (n_done !== 18 || !wrapped || n_run !== 0) begin
            bad++; $display("FAIL cont_wrap got=%0d/%b/%0d exp=18/1/0", n_done, wrapped, n_run);
        end
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (avg_restart) ok = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (!ok || busy !== 1'b0 || avg_restart !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort got=%b/%b/%b/%b exp=1/0/0/0", ok, busy, avg_restart, done);
        end
    endtask

    task automatic test_timeout();
        bit ok, seen_done, got;
        int hi;
        m_clken = 1'b1;
        wait_ready(ok);
        total++; if (!ok) begin
            bad++; $display("FAIL model_ready got=0 exp=1");
        end
        m_clken = 1'b0;
        cfg_timeout = 24'd100; cfg_n_acq = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi = 0; seen_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (avg_restart) hi++;
            else if (hi > 0) break;
        end
        total++; if (hi !== 100) begin
            bad++; $display("FAIL timeout_width got=%0d exp=100", hi);
        end
        total++; if (error !== 1'b1 || busy !== 1'b0 || seen_done) begin
            bad++; $display("FAIL timeout_state got=%b/%b/%b exp=1/0/0", error, busy, seen_done);
        end
        m_clken = 1'b1;
        cfg_timeout = 24'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (error !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL error_clear got=%b/%b exp=0/1", error, busy);
        end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (run_done) got = 1'b1;
        end
        total++; if (!got) begin
            bad++; $display("FAIL rerun_end got=0 exp=1");
        end
    endtask

    task automatic test_start_abort_same();
        bit stayed;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || avg_restart !== 1'b0) stayed = 1'b0;
            @(negedge clk);
        end
        total++; if (!stayed) begin
            bad++; $display("FAIL start_abort got=busy exp=idle");
        end
    endtask

    task automatic test_rst_mid_run();
        bit ok;
        wait_ready(ok);
        cfg_n_acq = 4'd2; cfg_count_max = 13'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (avg_restart) ok = 1'b1;
            else @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (!ok || avg_restart !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_rst got=%b/%b/%b exp=1/0/0", ok, avg_restart, busy);
        end
        total++; if (avg_count_max !== 13'h1FFF || avg_avg_on !== 1'b0 || acq_count !== 4'd0 ||
                     last_n_avg !== 19'd0 || error !== 1'b0 || done !== 1'b0 || run_done !== 1'b0) begin
            bad++; $display("FAIL async_rst_vals got=%0h/%b/%0d/%0h exp=1fff/0/0/0", avg_count_max, avg_avg_on, acq_count, last_n_avg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_finite_run();
        test_config_next_run();
        test_continuous_abort();
        test_timeout();
        test_start_abort_same();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
